pix_stream_packer: RTL and testbench

// - Downstream consumer of the test-pattern pixel stream (pix_valid/pix_r/g/b/pix_x/pix_y, one pixel per clk).
// - Converts RGB888 to RGB565, packs two pixels per 32-bit word and buffers words in a sync FIFO.
// - Presents words on a valid/ready stream with SOF/EOL/EOF tags. Feeds the framebuffer writer.
// - The upstream source has no backpressure. FIFO overflow drops the rest of the frame and sets a sticky flag.

---
 rtl/mistable_pix_pkg.sv | 24 ++
 rtl/pix_sync_fifo.sv | 57 +++++
 rtl/pix_stream_packer.sv | 124 ++++++++++++
 tb/tb_pix_stream_packer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mistable_pix_pkg.sv
// Shared types and helpers for the pixel stream packer.
// Holds the RGB565 pixel type and its conversion function, the bit positions
// of the SOF/EOL/EOF tags inside the 3-bit user field, and the packer states.
package mistable_pix_pkg;

   typedef logic [15:0] rgb565_t;

   localparam int USER_SOF = 0;
   localparam int USER_EOL = 1;
   localparam int USER_EOF = 2;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DROP
   } pack_state_t;

   // Truncating RGB888 -> RGB565 conversion (keep the top bits of each channel)
   function automatic rgb565_t to_rgb565(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
      return {r[7:3], g[7:2], b[7:3]};
   endfunction

endpackage

// File: rtl/pix_sync_fifo.sv
// Synchronous FIFO with a combinational (first-word-fall-through) read port.
// Ports:
//   clk, rst          clock and synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data    write request and data; ignored when full unless a pop
//                     happens in the same cycle
//   full              no free slot
//   rd_en             pop request; ignored when empty
//   rd_data           word at the head of the FIFO
//   empty             no word stored
module pix_sync_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // The extra pointer MSB tells a full FIFO apart from an empty one
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = rd_en && !empty;
   // When full, a same-cycle pop frees the very slot the write lands in
   assign do_push = wr_en && (!full || do_pop);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Pointer update
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage array, deliberately not reset
   always_ff @(posedge clk) begin
      if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/pix_stream_packer.sv
// Packs a raster pixel stream (one pixel per clk, no backpressure) into 32-bit
// words of two RGB565 pixels, tags them with SOF/EOL/EOF and buffers them in a
// FIFO presented as a valid/ready stream. On FIFO overflow the rest of the
// frame is dropped until the next (0,0) pixel.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   pix_valid                pixel qualifier
//   pix_r, pix_g, pix_b      RGB888 colour
//   pix_x, pix_y             pixel column / row
//   out_valid, out_ready     word stream handshake
//   out_data                 {pixel x+1 RGB565, pixel x RGB565}, x even
//   out_user                 [0]=SOF, [1]=EOL, [2]=EOF
//   overflow                 sticky: a word was dropped on a full FIFO
//   proto_err                sticky: odd pixel arrived with no held even half
//   frame_count              frames whose EOF word entered the FIFO (wraps)
module pix_stream_packer
   import mistable_pix_pkg::*;
#(
   parameter int W     = 256,
   parameter int H     = 240,
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_valid,
   input  logic [7:0]  pix_r,
   input  logic [7:0]  pix_g,
   input  logic [7:0]  pix_b,
   input  logic [15:0] pix_x,
   input  logic [15:0] pix_y,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [2:0]  out_user,
   output logic        overflow,
   output logic        proto_err,
   output logic [15:0] frame_count
);

   localparam logic [15:0] LAST_X = 16'(W - 1);
   localparam logic [15:0] LAST_Y = 16'(H - 1);

   pack_state_t state;
   logic        half_valid;
   logic        half_sof;
   rgb565_t     half_data;

   rgb565_t     pix_565;
   logic        is_origin;
   logic        take_pixel;
   logic        push_try;
   logic        pop;
   logic        push_ok;
   logic [2:0]  word_user;
   logic        fifo_full;
   logic        fifo_empty;
   logic [34:0] fifo_rd;

   assign pix_565   = to_rgb565(pix_r, pix_g, pix_b);
   assign is_origin = pix_valid && (pix_x == 16'd0) && (pix_y == 16'd0);
   // Outside RUN only the (0,0) pixel is taken; it is even, so it just gets held
   assign take_pixel = pix_valid && ((state == RUN) || is_origin);
   assign push_try   = take_pixel && pix_x[0] && half_valid;
   assign pop        = !fifo_empty && out_ready;
   assign push_ok    = !fifo_full || pop;

   // Tags come from the odd pixel; SOF remembers whether the held half was (0,0)
   always_comb begin
      word_user           = '0;
      word_user[USER_SOF] = half_sof;
      word_user[USER_EOL] = (pix_x == LAST_X);
      word_user[USER_EOF] = (pix_x == LAST_X) && (pix_y == LAST_Y);
   end

   // Packer FSM with held half-word, sticky flags and frame counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         half_valid  <= 1'b0;
         half_sof    <= 1'b0;
         half_data   <= '0;
         overflow    <= 1'b0;
         proto_err   <= 1'b0;
         frame_count <= '0;
      end else if (take_pixel) begin
         if (!pix_x[0]) begin
            // Even pixel (including a (0,0) restart) replaces any held half
            half_data  <= pix_565;
            half_valid <= 1'b1;
            half_sof   <= is_origin;
            state      <= RUN;
         end else if (half_valid) begin
            half_valid <= 1'b0;
            if (push_ok) begin
               if (word_user[USER_EOF]) frame_count <= frame_count + 16'd1;
            end else begin
               overflow <= 1'b1;
               state    <= DROP;
            end
         end else begin
            proto_err <= 1'b1;
         end
      end
   end

   pix_sync_fifo #(
      .WIDTH (35),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push_try),
      .wr_data ({word_user, pix_565, half_data}),
      .full    (fifo_full),
      .rd_en   (out_ready),
      .rd_data (fifo_rd),
      .empty   (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = fifo_rd[31:0];
   assign out_user  = fifo_rd[34:32];

endmodule

// File: tb/tb_pix_stream_packer.sv
// Self-checking bench for pix_stream_packer (W=8, H=2, DEPTH=4).
// Directed table and hand sequences cover the frame tags, overflow, resync,
// protocol error and reset; a randomized run is checked against a queue model.
module tb_pix_stream_packer;

   localparam int W     = 8;
   localparam int H     = 2;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pix_valid = 1'b0;
   logic [7:0]  pix_r = '0;
   logic [7:0]  pix_g = '0;
   logic [7:0]  pix_b = '0;
   logic [15:0] pix_x = '0;
   logic [15:0] pix_y = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [2:0]  out_user;
   logic        overflow;
   logic        proto_err;
   logic [15:0] frame_count;

   int compared   = 0;
   int mismatched = 0;

   pix_stream_packer #(
      .W     (W),
      .H     (H),
      .DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pix_valid   (pix_valid),
      .pix_r       (pix_r),
      .pix_g       (pix_g),
      .pix_b       (pix_b),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_user    (out_user),
      .overflow    (overflow),
      .proto_err   (proto_err),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   // Reference model: expected FIFO contents as a queue plus frame bookkeeping
   typedef struct packed {
      logic [2:0]  user;
      logic [31:0] data;
   } word_t;

   word_t       mq[$];
   bit          mInFrame;
   bit          mHeldValid;
   bit          mHeldSof;
   logic [15:0] mHeld;
   bit          mOverflow;
   bit          mProtoErr;
   int          mFrames;

   typedef struct {
      int          x;
      int          y;
      logic        expValid;
      logic [31:0] expData;
      logic [2:0]  expUser;
   } vec_t;

   vec_t vecs[W*H];

   function automatic logic [15:0] ref565(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
      int v;
      v = (int'(r) / 8) * 2048 + (int'(g) / 4) * 32 + int'(b) / 8;
      return 16'(v);
   endfunction

   function automatic logic [7:0] colR(input int x, input int y);
      return 8'(x * 37 + y * 91 + 5);
   endfunction

   function automatic logic [7:0] colG(input int x, input int y);
      return 8'(x * 53 + y * 17 + 100);
   endfunction

   function automatic logic [7:0] colB(input int x, input int y);
      return 8'(x * 29 + y * 71 + 200);
   endfunction

   function automatic logic [31:0] expWord(input int x, input int y);
      return {ref565(colR(x + 1, y), colG(x + 1, y), colB(x + 1, y)),
              ref565(colR(x, y), colG(x, y), colB(x, y))};
   endfunction

   task automatic modelStep(input logic v, input int x, input int y, input logic [7:0] r,
                            input logic [7:0] g, input logic [7:0] b, input logic rdy,
                            input logic rs);
      logic  origin;
      word_t w;
      if (rs) begin
         mq.delete();
         mInFrame   = 0;
         mHeldValid = 0;
         mHeldSof   = 0;
         mOverflow  = 0;
         mProtoErr  = 0;
         mFrames    = 0;
         return;
      end
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      origin = v && x == 0 && y == 0;
      if (v && (mInFrame || origin)) begin
         if (x % 2 == 0) begin
            mHeld      = ref565(r, g, b);
            mHeldValid = 1;
            mHeldSof   = origin;
            mInFrame   = 1;
         end else if (mHeldValid) begin
            mHeldValid = 0;
            w.data = {ref565(r, g, b), mHeld};
            w.user = {(x == W - 1) && (y == H - 1), (x == W - 1), mHeldSof};
            if (mq.size() < DEPTH) begin
               mq.push_back(w);
               if (w.user[2]) mFrames = (mFrames + 1) % 65536;
            end else begin
               mOverflow = 1;
               mInFrame  = 0;
            end
         end else begin
            mProtoErr = 1;
         end
      end
   endtask

   task automatic applyStimulus(input logic v, input int x, input int y, input logic [7:0] r,
                                input logic [7:0] g, input logic [7:0] b, input logic rdy);
      pix_valid = v;
      pix_x     = 16'(x);
      pix_y     = 16'(y);
      pix_r     = r;
      pix_g     = g;
      pix_b     = b;
      out_ready = rdy;
      @(posedge clk);
      modelStep(v, x, y, r, g, b, rdy, rst);
      #1;
   endtask

   task automatic applyPix(input int x, input int y, input logic rdy);
      applyStimulus(1'b1, x, y, colR(x, y), colG(x, y), colB(x, y), rdy);
   endtask

   task automatic applyIdle(input logic rdy);
      applyStimulus(1'b0, 0, 0, 8'h00, 8'h00, 8'h00, rdy);
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyIdle(1'b0);
      rst = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkAgainstModel();
      checkOutput("rnd_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         checkOutput("rnd_data", out_data, mq[0].data);
         checkOutput("rnd_user", 32'(out_user), 32'(mq[0].user));
      end
      checkOutput("rnd_overflow", 32'(overflow), 32'(mOverflow));
      checkOutput("rnd_proto_err", 32'(proto_err), 32'(mProtoErr));
      checkOutput("rnd_frame_count", 32'(frame_count), 32'(mFrames));
   endtask

   initial begin
      int          nValid;
      int          nWords;
      logic [31:0] firstWord;
      logic [31:0] lastWord;
      int          p;
      logic        v;
      logic        rdy;
      int          ex;
      int          ey;

      $display("[TB] start");
      doReset();
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_overflow", 32'(overflow), 32'd0);
      checkOutput("reset_proto_err", 32'(proto_err), 32'd0);
      checkOutput("reset_frame_count", 32'(frame_count), 32'd0);

      // One frame of a flat colour, consumer always ready
      for (int i = 0; i < W * H; i++) begin
         vecs[i].x        = i % W;
         vecs[i].y        = i / W;
         vecs[i].expValid = (i % 2 == 1);
         vecs[i].expData  = (i % 2 == 1) ? 32'hFC00FC00 : 32'h0;
         vecs[i].expUser  = 3'b000;
      end
      vecs[1].expUser  = 3'b001;
      vecs[7].expUser  = 3'b010;
      vecs[15].expUser = 3'b110;
      for (int i = 0; i < W * H; i++) begin
         applyStimulus(1'b1, vecs[i].x, vecs[i].y, 8'hFF, 8'h80, 8'h00, 1'b1);
         checkOutput($sformatf("t1_valid_%0d", i), 32'(out_valid), 32'(vecs[i].expValid));
         if (vecs[i].expValid) begin
            checkOutput($sformatf("t1_data_%0d", i), out_data, vecs[i].expData);
            checkOutput($sformatf("t1_user_%0d", i), 32'(out_user), 32'(vecs[i].expUser));
         end
      end
      checkOutput("t1_frame_count", 32'(frame_count), 32'd1);
      checkOutput("t1_overflow", 32'(overflow), 32'd0);

      // Restart, then an odd pixel with no even half
      applyPix(0, 0, 1'b1);
      applyPix(1, 0, 1'b1);
      checkOutput("t4_sof_valid", 32'(out_valid), 32'd1);
      checkOutput("t4_sof_user", 32'(out_user), 32'd1);
      applyPix(3, 0, 1'b1);
      checkOutput("t4_proto_err", 32'(proto_err), 32'd1);
      checkOutput("t4_no_push", 32'(out_valid), 32'd0);

      // Reset mid-frame with three words queued
      for (int x = 0; x < 6; x++) applyPix(x, 0, 1'b0);
      checkOutput("t5_queued_valid", 32'(out_valid), 32'd1);
      checkOutput("t5_pre_frame_count", 32'(frame_count), 32'd1);
      rst = 1'b1;
      applyPix(6, 0, 1'b0);
      rst = 1'b0;
      checkOutput("t5_out_valid", 32'(out_valid), 32'd0);
      checkOutput("t5_overflow", 32'(overflow), 32'd0);
      checkOutput("t5_proto_err", 32'(proto_err), 32'd0);
      checkOutput("t5_frame_count", 32'(frame_count), 32'd0);
      applyPix(7, 0, 1'b1);
      checkOutput("t5_idle_valid", 32'(out_valid), 32'd0);
      checkOutput("t5_idle_proto_err", 32'(proto_err), 32'd0);

      // Stream joins mid-frame; nothing until (0,0)
      doReset();
      nValid = 0;
      for (int i = 3; i < W * H; i++) begin
         applyPix(i % W, i / W, 1'b1);
         if (out_valid) nValid++;
      end
      checkOutput("t3_no_words", 32'(nValid), 32'd0);
      checkOutput("t3_proto_err", 32'(proto_err), 32'd0);
      applyPix(0, 0, 1'b1);
      applyPix(1, 0, 1'b1);
      checkOutput("t3_first_valid", 32'(out_valid), 32'd1);
      checkOutput("t3_first_user", 32'(out_user), 32'd1);
      checkOutput("t3_first_data", out_data, expWord(0, 0));

      // Consumer stalled for a whole frame: overflow, then drain and resync
      doReset();
      for (int i = 0; i < W * H; i++) applyPix(i % W, i / W, 1'b0);
      checkOutput("t2_valid", 32'(out_valid), 32'd1);
      checkOutput("t2_overflow", 32'(overflow), 32'd1);
      checkOutput("t2_frame_count", 32'(frame_count), 32'd0);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("t2_drain_valid_%0d", k), 32'(out_valid), 32'd1);
         checkOutput($sformatf("t2_drain_data_%0d", k), out_data, expWord(2 * k, 0));
         checkOutput($sformatf("t2_drain_user_%0d", k), 32'(out_user),
                     (k == 0) ? 32'd1 : ((k == 3) ? 32'd2 : 32'd0));
         applyIdle(1'b1);
      end
      checkOutput("t2_drained", 32'(out_valid), 32'd0);
      applyPix(0, 0, 1'b1);
      applyPix(1, 0, 1'b1);
      checkOutput("t2_resync_valid", 32'(out_valid), 32'd1);
      checkOutput("t2_resync_user", 32'(out_user), 32'd1);
      checkOutput("t2_resync_data", out_data, expWord(0, 0));
      checkOutput("t2_overflow_sticky", 32'(overflow), 32'd1);

      // Full FIFO, pop and push in the same cycle
      doReset();
      for (int x = 0; x < W; x++) applyPix(x, 0, 1'b0);
      applyPix(0, 1, 1'b0);
      applyPix(1, 1, 1'b1);
      checkOutput("t6_overflow", 32'(overflow), 32'd0);
      checkOutput("t6_head", out_data, expWord(2, 0));
      nWords    = 0;
      firstWord = '0;
      lastWord  = '0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) begin
            if (nWords == 0) firstWord = out_data;
            lastWord = out_data;
            nWords++;
         end
         applyIdle(1'b1);
      end
      checkOutput("t6_count", 32'(nWords), 32'(DEPTH));
      checkOutput("t6_first", firstWord, expWord(2, 0));
      checkOutput("t6_last", lastWord, expWord(0, 1));

      // Randomized raster traffic with gaps, jumps, skips and rare resets
      doReset();
      p = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst = ($urandom_range(0, 599) == 0);
         if ((cyc / 150) % 2 == 0) rdy = ($urandom_range(0, 3) != 0);
         else rdy = ($urandom_range(0, 3) == 0);
         v = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 63) == 0) p = $urandom_range(0, W * H - 1);
         if ($urandom_range(0, 63) == 0) p = (p + 1) % (W * H);
         ex = p % W;
         ey = p / W;
         if (v) p = (p + 1) % (W * H);
         applyStimulus(v, ex, ey, 8'($urandom), 8'($urandom), 8'($urandom), rdy);
         rst = 1'b0;
         checkAgainstModel();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
